// File: rtl/fft_stage_scheduler_if.sv
// Control and address bundle between the transform controller, the scheduler
// and the memory/butterfly pair.
interface fft_stage_scheduler_if #(
    parameter int unsigned N = 16
) ();
    localparam int unsigned A  = $clog2(N);
    localparam int unsigned T  = $clog2(N / 2);
    localparam int unsigned SW = $clog2(A) + 1;

    logic          i_start;
    logic          i_abort;
    logic          o_busy;
    logic          o_done;
    logic [SW-1:0] o_stage;
    logic          o_bank_sel;
    logic          o_rd_en;
    logic [A-1:0]  o_rd_addr_even;
    logic [A-1:0]  o_rd_addr_odd;
    logic [T-1:0]  o_twi_addr;
    logic          o_wr_en;
    logic [A-1:0]  o_wr_addr_top;
    logic [A-1:0]  o_wr_addr_bot;
    logic          o_result_bank;

    modport master (
        output i_start, i_abort,
        input  o_busy, o_done, o_stage, o_bank_sel, o_rd_en, o_rd_addr_even,
               o_rd_addr_odd, o_twi_addr, o_wr_en, o_wr_addr_top, o_wr_addr_bot,
               o_result_bank
    );

    modport slave (
        input  i_start, i_abort,
        output o_busy, o_done, o_stage, o_bank_sel, o_rd_en, o_rd_addr_even,
               o_rd_addr_odd, o_twi_addr, o_wr_en, o_wr_addr_top, o_wr_addr_bot,
               o_result_bank
    );
endinterface

// File: rtl/fft_stage_scheduler.sv
// Radix-2 DIT FFT stage sequencer: butterfly read/twiddle addresses, delayed write
// addresses and ping-pong bank select for all log2(N) stages.
module fft_stage_scheduler #(
    parameter int unsigned N      = 16,
    parameter int unsigned RD_LAT = 1,
    parameter int unsigned BF_LAT = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    fft_stage_scheduler_if.slave bus
);
    localparam int unsigned A  = $clog2(N);
    localparam int unsigned T  = $clog2(N / 2);
    localparam int unsigned SW = $clog2(A) + 1;
    localparam int unsigned L  = RD_LAT + BF_LAT;
    localparam int unsigned LW = $clog2(L + 1);

    localparam logic [T-1:0]  K_LAST      = T'(N / 2 - 1);
    localparam logic [SW-1:0] S_LAST      = SW'(A - 1);
    localparam logic [LW-1:0] D_LAST      = LW'(L - 1);
    localparam logic          RESULT_BANK = A % 2 == 1;

    typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

    state_e        state_q, state_d;
    logic [T-1:0]  k_q, k_d;
    logic [SW-1:0] stage_q, stage_d;
    logic          bank_q, bank_d;
    logic [LW-1:0] dcnt_q, dcnt_d;

    logic          abort;
    logic          start_ok;

    assign abort    = bus.i_abort && (state_q != StIdle);
    assign start_ok = (state_q == StIdle) && bus.i_start && !bus.i_abort;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            k_q     <= '0;
            stage_q <= '0;
            bank_q  <= 1'b0;
            dcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            stage_q <= stage_d;
            bank_q  <= bank_d;
            dcnt_q  <= dcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        stage_d = stage_q;
        bank_d  = bank_q;
        dcnt_d  = dcnt_q;
        if (abort) begin
            state_d = StIdle;
            k_d     = '0;
            stage_d = '0;
            bank_d  = 1'b0;
            dcnt_d  = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start_ok) begin
                        state_d = StIssue;
                        k_d     = '0;
                        stage_d = '0;
                        bank_d  = 1'b0;
                        dcnt_d  = '0;
                    end
                end
                StIssue: begin
                    if (k_q == K_LAST) begin
                        state_d = StDrain;
                        dcnt_d  = '0;
                    end else begin
                        k_d = k_q + 1'b1;
                    end
                end
                StDrain: begin
                    if (dcnt_q == D_LAST) begin
                        k_d    = '0;
                        dcnt_d = '0;
                        // Stage/bank stay put on the last stage so o_stage never exceeds A-1.
                        if (stage_q == S_LAST) begin
                            state_d = StDone;
                        end else begin
                            state_d = StIssue;
                            stage_d = stage_q + 1'b1;
                            bank_d  = ~bank_q;
                        end
                    end else begin
                        dcnt_d = dcnt_q + 1'b1;
                    end
                end
                StDone: begin
                    state_d = StIdle;
                    stage_d = '0;
                    bank_d  = 1'b0;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Butterfly index k within stage s: insert a zero at bit s for the even leg.
    logic [A-1:0]  k_ext;
    logic [A-1:0]  mask;
    logic [A-1:0]  even_c;
    logic [A-1:0]  odd_c;
    logic [A-1:0]  twi_full;
    logic [SW-1:0] twi_sh;

    always_comb begin
        k_ext    = A'(k_q);
        mask     = (A'(1) << stage_q) - A'(1);
        even_c   = ((k_ext >> stage_q) << (stage_q + 1'b1)) | (k_ext & mask);
        odd_c    = even_c + (A'(1) << stage_q);
        twi_sh   = S_LAST - stage_q;
        twi_full = (k_ext & mask) << twi_sh;
    end

    logic          issue;
    logic          rd_en_q;
    logic [A-1:0]  even_q;
    logic [A-1:0]  odd_q;
    logic [T-1:0]  twi_q;
    logic          busy_q;
    logic          done_q;
    logic [SW-1:0] stage_o_q;
    logic          bank_o_q;
    logic          result_q;

    assign issue = state_q == StIssue;

    // Outputs are registered one cycle behind the state so addresses and flags align.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_en_q   <= 1'b0;
            even_q    <= '0;
            odd_q     <= '0;
            twi_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            stage_o_q <= '0;
            bank_o_q  <= 1'b0;
            result_q  <= 1'b0;
        end else if (abort) begin
            rd_en_q   <= 1'b0;
            even_q    <= '0;
            odd_q     <= '0;
            twi_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            stage_o_q <= '0;
            bank_o_q  <= 1'b0;
            result_q  <= 1'b0;
        end else begin
            rd_en_q   <= issue;
            even_q    <= issue ? even_c : '0;
            odd_q     <= issue ? odd_c : '0;
            twi_q     <= issue ? twi_full[T-1:0] : '0;
            busy_q    <= (state_q == StIssue) || (state_q == StDrain);
            done_q    <= state_q == StDone;
            stage_o_q <= stage_q;
            bank_o_q  <= bank_q;
            if (start_ok) begin
                result_q <= 1'b0;
            end else if (state_q == StDone) begin
                result_q <= RESULT_BANK;
            end
        end
    end

    logic [L-1:0] pv_q;
    logic [A-1:0] pe_q [L];
    logic [A-1:0] po_q [L];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < L; i++) begin
                pv_q[i] <= 1'b0;
                pe_q[i] <= '0;
                po_q[i] <= '0;
            end
        end else if (abort) begin
            for (int i = 0; i < L; i++) begin
                pv_q[i] <= 1'b0;
                pe_q[i] <= '0;
                po_q[i] <= '0;
            end
        end else begin
            pv_q[0] <= rd_en_q;
            pe_q[0] <= even_q;
            po_q[0] <= odd_q;
            for (int i = 1; i < L; i++) begin
                pv_q[i] <= pv_q[i-1];
                pe_q[i] <= pe_q[i-1];
                po_q[i] <= po_q[i-1];
            end
        end
    end

    assign bus.o_busy         = busy_q;
    assign bus.o_done         = done_q;
    assign bus.o_stage        = stage_o_q;
    assign bus.o_bank_sel     = bank_o_q;
    assign bus.o_rd_en        = rd_en_q;
    assign bus.o_rd_addr_even = even_q;
    assign bus.o_rd_addr_odd  = odd_q;
    assign bus.o_twi_addr     = twi_q;
    assign bus.o_wr_en        = pv_q[L-1];
    assign bus.o_wr_addr_top  = pe_q[L-1];
    assign bus.o_wr_addr_bot  = po_q[L-1];
    assign bus.o_result_bank  = result_q;
endmodule

// File: tb/tb_fft_stage_scheduler.sv
// Directed bench for fft_stage_scheduler: N=8/L=3 and N=16/L=1 instances.
module tb_fft_stage_scheduler;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    fft_stage_scheduler_if #(.N(8))  bus8 ();
    fft_stage_scheduler_if #(.N(16)) bus16 ();

    fft_stage_scheduler #(.N(8), .RD_LAT(1), .BF_LAT(2)) dut8 (
        .clk(clk),
        .rst(rst),
        .bus(bus8.slave)
    );

    fft_stage_scheduler #(.N(16), .RD_LAT(1), .BF_LAT(0)) dut16 (
        .clk(clk),
        .rst(rst),
        .bus(bus16.slave)
    );

    int errors = 0;
    int checks = 0;

    int exp_ev [12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
    int exp_od [12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
    int exp_tw [12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};

    logic [31:0] rd_q[$];
    logic [31:0] wr_q[$];
    int          done_q[$];
    int          res_q[$];
    int          overlap;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        rd_q.delete();
        wr_q.delete();
        done_q.delete();
        res_q.delete();
        overlap = 0;
    endtask

    task automatic zero8(input string tag);
        chk(tag, {bus8.o_busy, bus8.o_done, bus8.o_stage, bus8.o_bank_sel, bus8.o_rd_en,
                  bus8.o_rd_addr_even, bus8.o_rd_addr_odd, bus8.o_twi_addr, bus8.o_wr_en,
                  bus8.o_wr_addr_top, bus8.o_wr_addr_bot, bus8.o_result_bank}, 64'd0);
    endtask

    // Leaves the bench 1 time unit after the edge that sampled i_start (cycle 0).
    task automatic start8();
        clear_logs();
        @(negedge clk);
        bus8.i_start = 1'b1;
        @(posedge clk);
        #1;
        bus8.i_start = 1'b0;
    endtask

    task automatic run8(input int ncyc, input bit hold);
        for (int c = 1; c <= ncyc; c++) begin
            @(posedge clk);
            #1;
            if (bus8.o_rd_en)
                rd_q.push_back({8'(c), 4'(bus8.o_rd_addr_even), 4'(bus8.o_rd_addr_odd),
                                4'(bus8.o_twi_addr), 4'(bus8.o_bank_sel), 4'(bus8.o_stage),
                                4'h0});
            if (bus8.o_wr_en)
                wr_q.push_back({8'(c), 4'(bus8.o_wr_addr_top), 4'(bus8.o_wr_addr_bot), 16'h0});
            if (bus8.o_done) begin
                done_q.push_back(c);
                res_q.push_back(int'(bus8.o_result_bank));
            end
            if (bus8.o_done && bus8.o_busy) overlap++;
            bus8.i_start = hold && (c <= 21);
        end
    endtask

    task automatic check_nominal(input string tag);
        int s;
        int j;
        logic [31:0] e;
        chk({tag, "_rd_count"}, 64'(rd_q.size()), 64'd12);
        chk({tag, "_wr_count"}, 64'(wr_q.size()), 64'd12);
        for (int i = 0; i < 12; i++) begin
            s = i / 4;
            j = i % 4;
            e = {8'(1 + s * 7 + j), 4'(exp_ev[i]), 4'(exp_od[i]), 4'(exp_tw[i]), 4'(s % 2),
                 4'(s), 4'h0};
            if (i < rd_q.size()) chk($sformatf("%s_rd%0d", tag, i), 64'(rd_q[i]), 64'(e));
            e = {8'(1 + s * 7 + j + 3), 4'(exp_ev[i]), 4'(exp_od[i]), 16'h0};
            if (i < wr_q.size()) chk($sformatf("%s_wr%0d", tag, i), 64'(wr_q[i]), 64'(e));
        end
        chk({tag, "_done_count"}, 64'(done_q.size()), 64'd1);
        if (done_q.size() > 0) begin
            chk({tag, "_done_cycle"}, 64'(done_q[0]), 64'd22);
            chk({tag, "_result_bank"}, 64'(res_q[0]), 64'd1);
        end
        chk({tag, "_busy_done_overlap"}, 64'(overlap), 64'd0);
        chk({tag, "_idle_after"}, 64'(bus8.o_busy), 64'd0);
    endtask

    int r16[$];
    int w16[$];
    int d16[$];
    int res16;

    initial begin
        bus8.i_start  = 1'b0;
        bus8.i_abort  = 1'b0;
        bus16.i_start = 1'b0;
        bus16.i_abort = 1'b0;
        overlap = 0;
        res16 = -1;

        #1;
        zero8("reset8");
        chk("reset16", {bus16.o_busy, bus16.o_done, bus16.o_rd_en, bus16.o_wr_en,
                        bus16.o_result_bank}, 64'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Abort together with start in IDLE: must stay idle.
        clear_logs();
        bus8.i_start = 1'b1;
        bus8.i_abort = 1'b1;
        @(posedge clk);
        #1;
        bus8.i_start = 1'b0;
        bus8.i_abort = 1'b0;
        run8(6, 1'b0);
        chk("abort_start_idle_rd", 64'(rd_q.size()), 64'd0);
        chk("abort_start_idle_busy", 64'(bus8.o_busy), 64'd0);

        start8();
        run8(26, 1'b0);
        check_nominal("nominal");

        start8();
        run8(26, 1'b1);
        check_nominal("restart_held");

        // Abort sampled at edge 13: stage 1 DRAIN.
        start8();
        run8(12, 1'b0);
        chk("abort_pre_rd", 64'(rd_q.size()), 64'd8);
        chk("abort_pre_wr", 64'(wr_q.size()), 64'd6);
        bus8.i_abort = 1'b1;
        @(posedge clk);
        #1;
        bus8.i_abort = 1'b0;
        zero8("abort_zero");
        clear_logs();
        run8(30, 1'b0);
        chk("abort_post_rd", 64'(rd_q.size()), 64'd0);
        chk("abort_post_wr", 64'(wr_q.size()), 64'd0);
        chk("abort_post_done", 64'(done_q.size()), 64'd0);
        start8();
        run8(26, 1'b0);
        check_nominal("after_abort");

        // Asynchronous reset between edges, mid stage 0.
        start8();
        run8(5, 1'b0);
        #3;
        rst = 1'b0;
        #1;
        zero8("rst_async");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        clear_logs();
        run8(10, 1'b0);
        chk("rst_idle_rd", 64'(rd_q.size()), 64'd0);
        chk("rst_idle_wr", 64'(wr_q.size()), 64'd0);
        chk("rst_idle_busy", 64'(bus8.o_busy), 64'd0);
        start8();
        run8(26, 1'b0);
        check_nominal("after_rst");

        // N=16, L=1.
        @(negedge clk);
        bus16.i_start = 1'b1;
        @(posedge clk);
        #1;
        bus16.i_start = 1'b0;
        for (int c = 1; c <= 45; c++) begin
            @(posedge clk);
            #1;
            if (bus16.o_rd_en) r16.push_back(c);
            if (bus16.o_wr_en) w16.push_back(c);
            if (bus16.o_done) begin
                d16.push_back(c);
                res16 = int'(bus16.o_result_bank);
            end
        end
        chk("n16_rd_count", 64'(r16.size()), 64'd32);
        chk("n16_wr_count", 64'(w16.size()), 64'd32);
        for (int i = 0; i < 32; i++) begin
            if (i < r16.size())
                chk($sformatf("n16_rd%0d", i), 64'(r16[i]), 64'(1 + (i / 8) * 9 + i % 8));
            if (i < w16.size())
                chk($sformatf("n16_wr%0d", i), 64'(w16[i]), 64'(2 + (i / 8) * 9 + i % 8));
        end
        chk("n16_done_count", 64'(d16.size()), 64'd1);
        if (d16.size() > 0) chk("n16_done_cycle", 64'(d16[0]), 64'd37);
        chk("n16_result_bank", 64'(res16), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fft_stage_scheduler.md
Name: fft_stage_scheduler

Overview:
- Sequences the radix-2 DIT FFT datapath during the transform phase: generates butterfly read addresses, twiddle ROM addresses, delayed write addresses and ping-pong bank select for all log2(N) stages.
- Sits between the top-level transform request and the memory/butterfly pair.
- Input data is already bit-reversed in bank 0 (RAM1); one butterfly issues per cycle.

Parameters:
- N, 16, FFT length; power of two, N >= 4; A = $clog2(N), T = $clog2(N/2).
- RD_LAT, 1, RAM/ROM read latency in cycles (>= 1).
- BF_LAT, 2, butterfly pipeline latency in cycles (>= 0); L = RD_LAT + BF_LAT.

Ports:
- clk  input  1  clock.
- rst  input  1  reset; asynchronous, active-low.
- i_start  input  1  start request; sampled only in IDLE.
- i_abort  input  1  synchronous abort; highest priority after reset.
- o_busy  output  1  high in ISSUE and DRAIN.
- o_done  output  1  one-cycle pulse when the last stage has fully written.
- o_stage  output  $clog2(A)+1  current stage index, 0..A-1.
- o_bank_sel  output  1  0: read RAM1 / write RAM2; 1: read RAM2 / write RAM1.
- o_rd_en  output  1  read enable for both RAM banks and the ROM.
- o_rd_addr_even  output  A  even-input address.
- o_rd_addr_odd  output  A  odd-input address.
- o_twi_addr  output  T  twiddle ROM address.
- o_wr_en  output  1  write enable for the destination bank.
- o_wr_addr_top  output  A  top-output write address (= delayed even address).
- o_wr_addr_bot  output  A  bottom-output write address (= delayed odd address).
- o_result_bank  output  1  bank holding the final result; valid from o_done onward.

Behaviour:
- Reset (rst low, async): state IDLE; all outputs 0; counters, bank select and write pipeline cleared.
- States: IDLE -> ISSUE on i_start. ISSUE -> DRAIN after butterfly counter k reaches N/2-1. DRAIN -> ISSUE (next stage) after L cycles. DRAIN -> DONE when the last stage has drained. DONE -> IDLE unconditionally after 1 cycle.
- In ISSUE, with k = 0..N/2-1 and stage s:
  - half = 2^s; even = ((k >> s) << (s+1)) | (k & (half-1)); odd = even + half.
  - twi = (k & (half-1)) << (A-1-s), truncated to T bits.
- o_rd_en = 1 exactly in ISSUE cycles; addresses are registered outputs valid in the same cycle as o_rd_en.
- Write pipeline: shift register of depth L carrying {valid, even, odd}. o_wr_en and write addresses appear exactly L cycles after the matching o_rd_en cycle. No holes: N/2 consecutive writes per stage.
- DRAIN: no reads issued; lasts exactly L cycles so the last write lands before the next stage reads that bank.
- At the DRAIN exit: o_bank_sel toggles, o_stage increments and k clears.
- o_bank_sel is constant across a stage's ISSUE and DRAIN. Stage 0 uses o_bank_sel = 0.
- Timing: o_done is high on the cycle A*(N/2+L)+1 clock edges after the edge that samples i_start. o_result_bank = A mod 2; it holds until the next start.
- o_done and o_busy are never high together.
- i_start while busy or in DONE: ignored.
- i_abort in any non-IDLE state: next cycle is IDLE with the write pipeline flushed. o_wr_en = 0 from the next cycle; no o_done; o_stage, o_bank_sel and o_result_bank cleared to 0.
- i_abort and i_start together in IDLE: abort wins, so the block stays in IDLE.
- Async reset mid-transform: behaves identically to power-on reset. Any in-flight writes are dropped.
- Back-to-back: i_start in the cycle after DONE (IDLE) is accepted normally.

Test Plan:
- N=8, RD_LAT=1, BF_LAT=2, start pulse. Required (even,odd,twi) issue sequence:
  - stage0: (0,1,0) (2,3,0) (4,5,0) (6,7,0)
  - stage1: (0,2,0) (1,3,2) (4,6,0) (5,7,2)
  - stage2: (0,4,0) (1,5,1) (2,6,2) (3,7,3)
  - o_done at cycle 22; o_result_bank = 1.
- Same config: every o_wr_en cycle lies exactly 3 cycles after its o_rd_en cycle with matching addresses. 12 writes total. o_bank_sel over stages 0,1,2 reads 0,1,0.
- N=16, BF_LAT=0: 8 reads per stage, DRAIN 1 cycle, 4 stages. o_done at cycle 4*(8+1)+1 = 37; o_result_bank = 0.
- Pulse i_start on every cycle while busy: exactly one o_done is produced, with identical timing to the single-start case.
- Assert i_abort during stage1 DRAIN, then restart. Required: o_wr_en low from the next cycle, no o_done, outputs 0. The restarted run reproduces scenario 1 exactly.
- Deassert rst asynchronously (between edges) mid-stage: all outputs go to 0 immediately; after release, the block idles until i_start.
